// File: rtl/stream_fifo_if.sv
// ----------------------------------------------------------------------------
// stream_fifo_if
// Handshake and status bundle between a producer/consumer pair and a
// stream_fifo instance.
//   master : the side that pushes/pops (drives flush, wr_en, data_in, rd_en)
//   slave  : the FIFO itself (drives data_out, full, empty, almost_full,
//            almost_empty, count, overflow, underflow)
// ----------------------------------------------------------------------------
interface stream_fifo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr_en, data_in, rd_en,
        input  data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en,
        output data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/stream_fifo.sv
// ----------------------------------------------------------------------------
// stream_fifo
// Parametrised synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and a selectable first-word-fall-through read mode.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rstn  : asynchronous active-low reset
//   bus   : stream_fifo_if slave modport
//           inputs  flush, wr_en, data_in, rd_en
//           outputs data_out, full, empty, almost_full, almost_empty,
//                   count, overflow, underflow
// ----------------------------------------------------------------------------
module stream_fifo #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input logic           clk,
    input logic           rstn,
    stream_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic w_full;
    logic w_empty;
    logic w_rdAcc;
    logic w_wrAcc;
    logic w_doRd;
    logic w_doWr;

    // Status is decoded only from the registered count so that no request
    // input can reach a status output combinationally.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A write into a full FIFO is still accepted when a read frees a slot in
    // the same cycle; flush suppresses both transfers.
    assign w_rdAcc = bus.rd_en & ~w_empty;
    assign w_wrAcc = bus.wr_en & (~w_full | w_rdAcc);
    assign w_doRd  = w_rdAcc & ~bus.flush;
    assign w_doWr  = w_wrAcc & ~bus.flush;

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.flush) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_doWr) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doRd) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doWr, w_doRd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (bus.wr_en && !w_wrAcc) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_en && !w_rdAcc) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (w_doWr) begin
            r_mem[r_wrPtr] <= bus.data_in;
        end
    end

    // Read data path: either the head word shown continuously, or a register
    // loaded with the head word on each accepted pop.
    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out = r_mem[r_rdPtr];
        end else begin : g_registered
            logic [WIDTH-1:0] r_dataOut;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_dataOut <= '0;
                end else if (w_doRd) begin
                    r_dataOut <= r_mem[r_rdPtr];
                end
            end

            assign bus.data_out = r_dataOut;
        end
    endgenerate

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= CW'(AF_LEVEL));
    assign bus.almost_empty = (r_count <= CW'(AE_LEVEL));
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule
